// File: rtl/exec_wb_stage_pkg.sv
// Shared definitions for the execute/write-back stage: opcodes, FSM states
// and default widths.
package exec_wb_stage_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_REG_AW = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    // True for opcodes that complete in the single-cycle ALU.
    function automatic logic is_alu_op(input op_e o);
        logic r;
        case (o)
            OP_MUL:  r = 1'b0;
            OP_ILL:  r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_seq32.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// always exactly WIDTH iterations; yields the low WIDTH bits of the product.
module mul_seq32
    import exec_wb_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    count_r;
    logic             active_r;

    logic [WIDTH-1:0] addend_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             last_s;

    // Partial-product add for the current iteration.
    always_comb begin
        addend_s   = {WIDTH{1'b0}};
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        acc_next_s = acc_r + addend_s;
        last_s     = active_r && (count_r == CW'(WIDTH - 1));
    end

    // The final iteration is folded into the product output so the caller
    // can capture it on the same edge that retires the count.
    assign done    = last_s;
    assign product = acc_next_s;

    // Shift registers, accumulator and iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            active_r <= 1'b0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            active_r <= 1'b1;
        end else if (active_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            if (last_s) begin
                count_r  <= {CW{1'b0}};
                active_r <= 1'b0;
            end else begin
                count_r  <= count_r + CW'(1);
                active_r <= 1'b1;
            end
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            count_r  <= count_r;
            active_r <= active_r;
        end
    end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute + write-back stage feeding the register-file write port: single-cycle
// ALU ops, iterative multiply, one operation in flight.
module exec_wb_stage
    import exec_wb_stage_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  opa,
    input  logic [WIDTH-1:0]  opb,
    input  logic [REG_AW-1:0] dest,
    output logic [WIDTH-1:0]  WriteData,
    output logic [REG_AW-1:0] WriteReg,
    output logic              RegWrite,
    output logic              busy,
    output logic              op_err
);

    state_e            state_r;
    state_e            next_state_s;
    op_e               op_s;
    logic              accept_s;
    logic [WIDTH-1:0]  alu_s;
    logic [REG_AW-1:0] dest_r;

    logic              mul_start_s;
    logic              mul_done_s;
    logic [WIDTH-1:0]  mul_product_s;

    logic              wb_load_s;
    logic [WIDTH-1:0]  wb_data_s;
    logic [REG_AW-1:0] wb_reg_s;
    logic              err_s;

    logic [WIDTH-1:0]  write_data_r;
    logic [REG_AW-1:0] write_reg_r;
    logic              reg_write_r;
    logic              op_err_r;

    assign op_s     = op_e'(op);
    assign in_ready = (state_r == ST_IDLE);
    assign busy     = ~in_ready;
    assign accept_s = in_valid && in_ready;

    assign WriteData = write_data_r;
    assign WriteReg  = write_reg_r;
    assign RegWrite  = reg_write_r;
    assign op_err    = op_err_r;

    mul_seq32 #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (opa),
        .b       (opb),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle ALU evaluated on the operands being accepted.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (op_s)
            OP_ADD:  alu_s = opa + opb;
            OP_SUB:  alu_s = opa - opb;
            OP_AND:  alu_s = opa & opb;
            OP_OR:   alu_s = opa | opb;
            OP_XOR:  alu_s = opa ^ opb;
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and write-back decode.
    always_comb begin
        next_state_s = state_r;
        mul_start_s  = 1'b0;
        wb_load_s    = 1'b0;
        wb_data_s    = alu_s;
        wb_reg_s     = dest;
        err_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op_s == OP_MUL) begin
                        next_state_s = ST_MUL;
                        mul_start_s  = 1'b1;
                    end else if (is_alu_op(op_s)) begin
                        next_state_s = ST_WB;
                        wb_load_s    = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                        err_s        = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    next_state_s = ST_WB;
                    wb_load_s    = 1'b1;
                    wb_data_s    = mul_product_s;
                    wb_reg_s     = dest_r;
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Destination held for the multiply, whose write-back is many cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_r <= {REG_AW{1'b0}};
        end else if (accept_s) begin
            dest_r <= dest;
        end else begin
            dest_r <= dest_r;
        end
    end

    // Write-port registers: data/address hold between write strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_data_r <= {WIDTH{1'b0}};
            write_reg_r  <= {REG_AW{1'b0}};
            reg_write_r  <= 1'b0;
            op_err_r     <= 1'b0;
        end else begin
            reg_write_r <= wb_load_s;
            op_err_r    <= err_s;
            if (wb_load_s) begin
                write_data_r <= wb_data_s;
                write_reg_r  <= wb_reg_s;
            end else begin
                write_data_r <= write_data_r;
                write_reg_r  <= write_reg_r;
            end
        end
    end

endmodule

// File: tb/tb_exec_wb_stage.sv
// Self-checking bench for exec_wb_stage: directed cases plus random ops checked
// against a plain-arithmetic reference model.
module tb_exec_wb_stage;

    localparam int W = 32;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [1:0]  dest;
    logic [31:0] WriteData;
    logic [1:0]  WriteReg;
    logic        RegWrite;
    logic        busy;
    logic        op_err;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_wd = 32'd0;
    logic [1:0]  last_wr = 2'd0;

    exec_wb_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .dest      (dest),
        .WriteData (WriteData),
        .WriteReg  (WriteReg),
        .RegWrite  (RegWrite),
        .busy      (busy),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        case (o)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op at #1 after a posedge and follow it cycle by cycle until idle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] d, input bit hold);
        logic [31:0] exp_d;
        int          lat;
        exp_d = ref_result(o, a, b);
        lat   = (o == 3'd6) ? W : 0;
        op = o; opa = a; opb = b; dest = d; in_valid = 1'b1;
        chk("ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        if (hold) begin
            op = 3'($urandom); opa = $urandom; opb = $urandom; dest = 2'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        if (o == 3'd7) begin
            chk("err_pulse", 32'(op_err), 32'd1);
            chk("err_nowrite", 32'(RegWrite), 32'd0);
            chk("err_ready", 32'(in_ready), 32'd1);
            chk("err_wd_hold", WriteData, last_wd);
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("err_one_cycle", 32'(op_err), 32'd0);
            chk("err_nowrite2", 32'(RegWrite), 32'd0);
            return;
        end
        for (int j = 0; j <= lat + 1; j++) begin
            chk("regwrite", 32'(RegWrite), 32'(j == lat));
            chk("ready", 32'(in_ready), 32'(j == lat + 1));
            chk("busy", 32'(busy), 32'(j != lat + 1));
            chk("op_err_quiet", 32'(op_err), 32'd0);
            if (j >= lat) begin
                chk("wdata", WriteData, exp_d);
                chk("wreg", 32'(WriteReg), 32'(d));
            end else begin
                chk("wdata_prev", WriteData, last_wd);
                chk("wreg_prev", 32'(WriteReg), 32'(last_wr));
            end
            if (j == lat + 1) begin
                in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        last_wd = exp_d;
        last_wr = d;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 3'd0; opa = 32'd0; opb = 32'd0; dest = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_op_err", 32'(op_err), 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_wreg", 32'(WriteReg), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(3'd0, 32'd13, 32'd3, 2'd0, 1'b0);
        do_op(3'd1, 32'd3, 32'd13, 2'd1, 1'b0);
        do_op(3'd5, 32'hFFFF_FFFF, 32'd1, 2'd3, 1'b0);
        do_op(3'd5, 32'd1, 32'hFFFF_FFFF, 2'd2, 1'b0);
        do_op(3'd6, 32'd453, 32'd30, 2'd2, 1'b0);
        do_op(3'd6, 32'hFFFF_FFFF, 32'd2, 2'd1, 1'b0);
        do_op(3'd6, 32'd0, 32'd12345, 2'd3, 1'b0);
        do_op(3'd6, 32'd7, 32'd9, 2'd1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            do_op(3'd0, 32'(k * 100), 32'd5, 2'(k), 1'b0);
        end
        do_op(3'd7, 32'd1, 32'd2, 2'd3, 1'b0);
        do_op(3'd7, 32'd5, 32'd6, 2'd1, 1'b1);
        do_op(3'd4, 32'hA5A5_0F0F, 32'hFFFF_0000, 2'd2, 1'b0);

        for (int k = 0; k < 40; k++) begin
            do_op(3'($urandom_range(0, 7)), $urandom, $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a multiply must abort without any write.
        op = 3'd6; opa = 32'd5; opb = 32'd7; dest = 2'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_mul_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_mid_regwrite", 32'(RegWrite), 32'd0);
        end
        reset = 1'b0;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_wdata", WriteData, 32'd0);
        chk("rst_mid_wreg", 32'(WriteReg), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_write", 32'(RegWrite), 32'd0);
        end
        last_wd = 32'd0;
        last_wr = 2'd0;
        do_op(3'd3, 32'h0000_F000, 32'h0000_000F, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
